delay_chain_arbiter: RTL and testbench
======================================

Name: delay_chain_arbiter

Overview:
- Shares one `delay_chain` instance between NUM_REQ requesters.
- Grants the chain to one requester at a time using round-robin.
- Launches a single-cycle pulse into the chain and watches for it to come out.
- Reports completion or timeout to the granted requester, then drains the chain before the next grant.
- Sits between the clock-delay consumers in the bridge and the shared delay path.

Parameters:
- NUM_REQ, 4: number of requesters (≥2).
- DELAY_CYCLES, 6: configured depth of the attached delay chain; also sets the drain length.
- TIMEOUT, 8 (DELAY_CYCLES+2): WAIT cycles allowed before declaring the chain lost.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the clk rising edge.
- req  in  NUM_REQ  level request per requester.
- gnt  out  NUM_REQ  one-hot grant; held for the whole operation.
- done  out  NUM_REQ  one-cycle completion pulse on the granted bit.
- err  out  1  one-cycle timeout pulse.
- busy  out  1  high whenever state ≠ IDLE.
- chain_in  out  1  pulse driven into the delay chain input.
- chain_out  in  1  delay chain output.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE; gnt, done, err, busy, chain_in all 0.
  - Wait counter = 0.
  - RR pointer = NUM_REQ-1, so requester 0 has first priority.
  - Applies mid-operation too: an in-flight operation is abandoned with no done or err.
- All outputs are registered. State encoding is free; states are IDLE, LAUNCH, WAIT, DRAIN.
- IDLE:
  - chain_out is ignored.
  - If req ≠ 0, select the first set bit searching upward from pointer+1 with wrap-around.
  - At that edge: gnt = one-hot(sel), pointer = sel, chain_in = 1, busy = 1, go to LAUNCH.
- LAUNCH:
  - Lasts exactly one cycle; chain_in is high only in this cycle.
  - Next edge: chain_in = 0, counter = 0, go to WAIT.
  - chain_out is ignored.
- WAIT:
  - Each edge: if chain_out = 1, then done[sel] = 1, gnt = 0, busy = 0, go to IDLE.
  - Else if counter = TIMEOUT-1, then err = 1, gnt = 0, counter = 0, go to DRAIN.
  - Else counter increments.
  - If chain_out and the timeout occur on the same edge, chain_out wins (done, no err).
- DRAIN:
  - Lasts DELAY_CYCLES cycles; chain_in = 0, chain_out is ignored, busy = 1.
  - This flushes any late pulse. Then go to IDLE.
- Latency with a healthy chain of depth D = DELAY_CYCLES:
  - gnt rises at edge k; done is high after edge k+D+1 for one cycle.
  - The next grant is possible at edge k+D+2, giving a back-to-back period of D+2 cycles.
- Pulse widths: done and err are exactly one cycle; done is only ever asserted on the granted index.
- req deassertion after grant is ignored; the operation completes and done is still issued.
- req bits asserted during an operation wait for IDLE; there is no preemption.
- Counter width: $clog2(TIMEOUT+1). The counter must not wrap while in WAIT.
- gnt is one-hot or zero at all times; gnt ≠ 0 implies busy = 1.

Test Plan:
- Single request, D=6: req=0100 held → gnt=0100 and chain_in high for 1 cycle after the same edge; done=0100 for 1 cycle, 7 cycles after gnt rose; err=0.
- Round-robin fairness: req=1111 continuously → grant order 0001, 0010, 0100, 1000, 0001, with grant rises spaced 8 cycles apart.
- Timeout: chain_out tied 0 → err pulses 8 cycles after chain_in; no done; busy stays high 6 more cycles; next grant follows.
- Late pulse: chain_out forced high 2 cycles into DRAIN → no done and no extra grant.
- Dropped request: req[3] pulsed for 1 cycle → gnt=1000 is held through WAIT and done=1000 is still issued.
- Reset mid-WAIT: rst_n low for 1 edge → gnt=0, busy=0, chain_in=0, no done or err. After release, req=1111 → gnt=0001.
- Spurious input: chain_out high in IDLE with req=0 → all outputs stay 0.

Source files
------------

// File: rtl/delay_chain_arbiter_if.sv
// Request/grant and delay-chain handshake bundle shared by the arbiter and its requesters.
// The arbiter takes the slave side and the requester/chain side takes the master side.
interface delay_chain_arbiter_if #(
   parameter int NUM_REQ = 4
);

   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] gnt;
   logic [NUM_REQ-1:0] done;
   logic               err;
   logic               busy;
   logic               chain_in;
   logic               chain_out;

   modport master (
      output req,
      output chain_out,
      input  gnt,
      input  done,
      input  err,
      input  busy,
      input  chain_in
   );

   modport slave (
      input  req,
      input  chain_out,
      output gnt,
      output done,
      output err,
      output busy,
      output chain_in
   );

endinterface

// File: rtl/delay_chain_arbiter.sv
// Round-robin arbiter sharing one delay chain: launch a pulse, wait for it, report done or
// timeout, and flush the chain before the next grant.
module delay_chain_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int DELAY_CYCLES = 6,
   parameter int TIMEOUT      = DELAY_CYCLES + 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   delay_chain_arbiter_if.slave bus
);

   localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CMAX = (TIMEOUT > DELAY_CYCLES) ? TIMEOUT : DELAY_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_DRAIN
   } state_t;

   state_t             r_state;
   state_t             w_nextState;
   logic [PW-1:0]      r_ptr;
   logic [CW-1:0]      r_cnt;
   logic [NUM_REQ-1:0] r_gnt;
   logic [NUM_REQ-1:0] r_done;
   logic               r_err;
   logic               r_busy;
   logic               r_chainIn;

   logic [PW-1:0]      w_sel;
   logic [PW-1:0]      w_idx;
   logic               w_found;
   logic               w_waitTimeout;
   logic               w_drainEnd;
   logic [PW-1:0]      w_ptrNext;
   logic [CW-1:0]      w_cntNext;
   logic [NUM_REQ-1:0] w_gntNext;
   logic [NUM_REQ-1:0] w_doneNext;
   logic               w_errNext;
   logic               w_busyNext;
   logic               w_chainInNext;

   // Search upward from the last winner so the most recently served requester goes last.
   always_comb begin
      w_sel   = r_ptr;
      w_idx   = r_ptr;
      w_found = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         w_idx = PW'((int'(r_ptr) + i) % NUM_REQ);
         if (!w_found && bus.req[w_idx]) begin
            w_found = 1'b1;
            w_sel   = w_idx;
         end
      end
   end

   assign w_waitTimeout = (r_cnt == CW'(TIMEOUT - 1));
   assign w_drainEnd    = (r_cnt == CW'(DELAY_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_ptr     <= PW'(NUM_REQ - 1);
         r_cnt     <= '0;
         r_gnt     <= '0;
         r_done    <= '0;
         r_err     <= 1'b0;
         r_busy    <= 1'b0;
         r_chainIn <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_ptr     <= w_ptrNext;
         r_cnt     <= w_cntNext;
         r_gnt     <= w_gntNext;
         r_done    <= w_doneNext;
         r_err     <= w_errNext;
         r_busy    <= w_busyNext;
         r_chainIn <= w_chainInNext;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE:   if (w_found) w_nextState = S_LAUNCH;
         S_LAUNCH: w_nextState = S_WAIT;
         S_WAIT: begin
            if (bus.chain_out)      w_nextState = S_IDLE;
            else if (w_waitTimeout) w_nextState = S_DRAIN;
         end
         S_DRAIN:  if (w_drainEnd) w_nextState = S_IDLE;
         default:  w_nextState = S_IDLE;
      endcase
   end

   // A pulse arriving on the timeout edge still counts as completion.
   always_comb begin
      w_ptrNext     = r_ptr;
      w_cntNext     = r_cnt;
      w_gntNext     = r_gnt;
      w_doneNext    = '0;
      w_errNext     = 1'b0;
      w_busyNext    = r_busy;
      w_chainInNext = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_gntNext     = {{(NUM_REQ - 1){1'b0}}, 1'b1} << w_sel;
               w_ptrNext     = w_sel;
               w_chainInNext = 1'b1;
               w_busyNext    = 1'b1;
            end
         end
         S_LAUNCH: begin
            w_cntNext = '0;
         end
         S_WAIT: begin
            if (bus.chain_out) begin
               w_doneNext = r_gnt;
               w_gntNext  = '0;
               w_busyNext = 1'b0;
            end else if (w_waitTimeout) begin
               w_errNext = 1'b1;
               w_gntNext = '0;
               w_cntNext = '0;
            end else begin
               w_cntNext = r_cnt + 1'b1;
            end
         end
         S_DRAIN: begin
            if (w_drainEnd) begin
               w_busyNext = 1'b0;
               w_cntNext  = '0;
            end else begin
               w_cntNext = r_cnt + 1'b1;
            end
         end
         default: begin
            w_gntNext  = '0;
            w_busyNext = 1'b0;
         end
      endcase
   end

   assign bus.gnt      = r_gnt;
   assign bus.done     = r_done;
   assign bus.err      = r_err;
   assign bus.busy     = r_busy;
   assign bus.chain_in = r_chainIn;

endmodule

// File: tb/tb_delay_chain_arbiter.sv
// Directed bench for delay_chain_arbiter: a model delay chain plus a scoreboard of expected
// grant/done/err events with the edge on which each must appear.
module tb_delay_chain_arbiter;

   localparam int NREQ   = 4;
   localparam int D      = 6;
   localparam int TMO    = D + 2;
   localparam int EV_GNT  = 0;
   localparam int EV_DONE = 1;
   localparam int EV_ERR  = 2;

   typedef struct {
      int             kind;
      logic [NREQ-1:0] val;
      int             cyc;
   } evt_t;

   logic clk;
   logic rst_n;
   logic chainHealthy;
   logic chainForce;
   logic [D-1:0] srReg = '0;
   logic [NREQ-1:0] prevGnt = '0;
   int cyc = 0;
   int checks = 0;
   int failures = 0;
   int k;
   evt_t sb[$];

   delay_chain_arbiter_if #(.NUM_REQ(NREQ)) bus ();

   delay_chain_arbiter #(
      .NUM_REQ(NREQ),
      .DELAY_CYCLES(D),
      .TIMEOUT(TMO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Model delay chain: D flops, optionally broken (output tied low) or forced high.
   always @(posedge clk) begin
      srReg <= {srReg[D-2:0], bus.chain_in};
      cyc   <= cyc + 1;
   end

   assign bus.chain_out = chainForce | (chainHealthy & srReg[D-1]);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag, input logic [NREQ-1:0] eGnt,
                              input logic [NREQ-1:0] eDone, input logic eErr,
                              input logic eBusy, input logic eChainIn);
      check({tag, ".gnt"},      32'(bus.gnt),      32'(eGnt));
      check({tag, ".done"},     32'(bus.done),     32'(eDone));
      check({tag, ".err"},      32'(bus.err),      32'(eErr));
      check({tag, ".busy"},     32'(bus.busy),     32'(eBusy));
      check({tag, ".chain_in"}, 32'(bus.chain_in), 32'(eChainIn));
   endtask

   task automatic applyStimulus(input logic [NREQ-1:0] reqVal);
      bus.req = reqVal;
   endtask

   task automatic pushEvt(input int kind, input logic [NREQ-1:0] val, input int when);
      evt_t e;
      e.kind = kind;
      e.val  = val;
      e.cyc  = when;
      sb.push_back(e);
   endtask

   task automatic matchEvent(input int kind, input logic [NREQ-1:0] val);
      evt_t e;
      check("sb_expected_event", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check("evt_kind",  32'(kind), 32'(e.kind));
         check("evt_value", 32'(val),  32'(e.val));
         check("evt_cycle", 32'(cyc),  32'(e.cyc));
      end
   endtask

   task automatic waitQueueEmpty(input int maxCycles);
      int n;
      n = 0;
      while (sb.size() != 0 && n < maxCycles) begin
         @(negedge clk);
         n++;
      end
      check("queue_empty", 32'(sb.size()), 32'd0);
   endtask

   // Monitor: every grant rise, done pulse and err pulse must match the next scoreboard entry.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         check("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
         check("gnt_implies_busy", 32'((bus.gnt == '0) || bus.busy), 32'd1);
         if (bus.gnt != '0 && bus.gnt != prevGnt) matchEvent(EV_GNT, bus.gnt);
         if (bus.done != '0) matchEvent(EV_DONE, bus.done);
         if (bus.err) matchEvent(EV_ERR, '0);
      end
      prevGnt <= bus.gnt;
   end

   initial begin
      bus.req      = '0;
      rst_n        = 1'b0;
      chainHealthy = 1'b1;
      chainForce   = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset", '0, '0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;

      chainForce = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checkOutput("spurious", '0, '0, 1'b0, 1'b0, 1'b0);
      end
      chainForce = 1'b0;

      // Round robin with all requesting: 0,1,2,3,0 spaced D+2 apart.
      k = cyc + 1;
      applyStimulus(4'b1111);
      for (int i = 0; i < 5; i++) begin
         pushEvt(EV_GNT,  4'(1 << (i % 4)), k + (D + 2) * i);
         pushEvt(EV_DONE, 4'(1 << (i % 4)), k + (D + 2) * i + D + 1);
      end
      repeat (33) @(negedge clk);
      applyStimulus('0);
      waitQueueEmpty(20);

      // Single request, chain_in pulse width and done latency.
      k = cyc + 1;
      applyStimulus(4'b0100);
      pushEvt(EV_GNT,  4'b0100, k);
      pushEvt(EV_DONE, 4'b0100, k + D + 1);
      @(negedge clk);
      checkOutput("single_launch", 4'b0100, '0, 1'b0, 1'b1, 1'b1);
      applyStimulus('0);
      @(negedge clk);
      checkOutput("single_wait", 4'b0100, '0, 1'b0, 1'b1, 1'b0);
      waitQueueEmpty(20);
      @(negedge clk);
      checkOutput("single_idle", '0, '0, 1'b0, 1'b0, 1'b0);

      // Timeout with a broken chain, late pulse in drain, queued request follows.
      k = cyc + 1;
      chainHealthy = 1'b0;
      applyStimulus(4'b1000);
      pushEvt(EV_GNT,  4'b1000, k);
      pushEvt(EV_ERR,  4'b0000, k + TMO + 1);
      pushEvt(EV_GNT,  4'b0001, k + TMO + D + 2);
      pushEvt(EV_DONE, 4'b0001, k + TMO + D + 2 + D + 1);
      @(negedge clk);
      applyStimulus(4'b0001);
      checkOutput("to_launch", 4'b1000, '0, 1'b0, 1'b1, 1'b1);
      repeat (TMO) @(negedge clk);
      checkOutput("to_wait_last", 4'b1000, '0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("to_err", '0, '0, 1'b1, 1'b1, 1'b0);
      chainHealthy = 1'b1;
      for (int i = 1; i < D; i++) begin
         @(negedge clk);
         chainForce = (i == 2);
         checkOutput("to_drain", '0, '0, 1'b0, 1'b1, 1'b0);
      end
      chainForce = 1'b0;
      @(negedge clk);
      checkOutput("to_drain_end", '0, '0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("to_next_gnt", 4'b0001, '0, 1'b0, 1'b1, 1'b1);
      applyStimulus('0);
      waitQueueEmpty(20);

      // Request dropped right after grant still completes.
      k = cyc + 1;
      applyStimulus(4'b1000);
      pushEvt(EV_GNT,  4'b1000, k);
      pushEvt(EV_DONE, 4'b1000, k + D + 1);
      @(negedge clk);
      applyStimulus('0);
      for (int i = 1; i <= D; i++) begin
         @(negedge clk);
         checkOutput("drop_hold", 4'b1000, '0, 1'b0, 1'b1, 1'b0);
      end
      waitQueueEmpty(20);

      // Reset in WAIT abandons the operation and restores requester 0 priority.
      k = cyc + 1;
      applyStimulus(4'b0100);
      pushEvt(EV_GNT, 4'b0100, k);
      @(negedge clk);
      applyStimulus('0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("rst_mid", '0, '0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         checkOutput("post_rst_idle", '0, '0, 1'b0, 1'b0, 1'b0);
      end
      k = cyc + 1;
      applyStimulus(4'b1111);
      pushEvt(EV_GNT,  4'b0001, k);
      pushEvt(EV_DONE, 4'b0001, k + D + 1);
      @(negedge clk);
      applyStimulus('0);
      waitQueueEmpty(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
